// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state and the
// priority-ordered stall/flush cause, also consumed by trace logic.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_e;

    // Listed highest priority first
    typedef enum logic [2:0] {
        CAUSE_HALT     = 3'd0,
        CAUSE_DMEM     = 3'd1,
        CAUSE_WBHALT   = 3'd2,
        CAUSE_REDIRECT = 3'd3,
        CAUSE_LOADUSE  = 3'd4,
        CAUSE_IMEM     = 3'd5,
        CAUSE_NONE     = 3'd6
    } pipe_cause_e;

    // Resolve the winning cause for this cycle
    function automatic pipe_cause_e pick_cause(
        input pipe_state_e st,
        input logic        dmem,
        input logic        wbh,
        input logic        red,
        input logic        lu,
        input logic        imem
    );
        pipe_cause_e c;
        if (st == ST_HALT)  c = CAUSE_HALT;
        else if (dmem)      c = CAUSE_DMEM;
        else if (wbh)       c = CAUSE_WBHALT;
        else if (red)       c = CAUSE_REDIRECT;
        else if (lu)        c = CAUSE_LOADUSE;
        else if (imem)      c = CAUSE_IMEM;
        else                c = CAUSE_NONE;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating performance counter with synchronous clear.
// Instantiated by pipe_ctrl only when PIPE_PERF_EN is defined.
module pipe_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // Counter register, clear wins over increment
    always_ff @(posedge clk) begin
        if (clr_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall/flush sources into register controls.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_stall,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             imem_cancel,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    pipe_cause_e cause;

    assign cause = pick_cause(state_q, dmem_busy, wb_halt,
                              ex_redirect, lu_stall, imem_busy);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state from the winning cause
    always_comb begin
        state_d = ST_RUN;
        unique case (cause)
            CAUSE_HALT:     state_d = ST_HALT;
            CAUSE_DMEM:     state_d = ST_DWAIT;
            CAUSE_WBHALT:   state_d = ST_HALT;
            CAUSE_REDIRECT: state_d = ST_RUN;
            CAUSE_LOADUSE:  state_d = imem_busy ? ST_IWAIT : ST_RUN;
            CAUSE_IMEM:     state_d = ST_IWAIT;
            CAUSE_NONE:     state_d = ST_RUN;
            default:        state_d = ST_RUN;
        endcase
    end

    // Control outputs; everything held low while in reset
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
        imem_cancel = 1'b0;
        if (!rst) begin
            unique case (cause)
                CAUSE_HALT, CAUSE_DMEM, CAUSE_WBHALT: ;
                CAUSE_REDIRECT: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                    imem_cancel = (state_q == ST_IWAIT) || imem_busy;
                end
                CAUSE_LOADUSE: begin
                    idex_flush  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end
                CAUSE_IMEM: begin
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end
                default: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end
            endcase
        end
    end

    assign halted = (state_q == ST_HALT);

`ifdef PIPE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst && !pc_write && !halted;
    assign flush_inc = !rst && (cause == CAUSE_REDIRECT);

    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );
`else
    logic [CNT_W-1:0] perf_unused;
    assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl using a per-cycle expected queue.
// Counter checks compile in when PIPE_PERF_EN is defined.
module tb_pipe_ctrl;

    localparam int CW = 4;

    // Output vector: {pc,ifid_w,ifid_f,idex_f,exmem,memwb,cancel,halted}
    localparam logic [7:0] ADV   = 8'b1100_1100;
    localparam logic [7:0] FRZ   = 8'b0000_0000;
    localparam logic [7:0] LU    = 8'b0001_1100;
    localparam logic [7:0] IMB   = 8'b0110_1100;
    localparam logic [7:0] RED   = 8'b1111_1100;
    localparam logic [7:0] REDC  = 8'b1111_1110;
    localparam logic [7:0] HLT   = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst, lu_stall, imem_busy, dmem_busy, ex_redirect, wb_halt;
    logic pc_write, ifid_write, ifid_flush, idex_flush;
    logic exmem_write, memwb_write, imem_cancel, halted;
`ifdef PIPE_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .lu_stall    (lu_stall),
        .imem_busy   (imem_busy),
        .dmem_busy   (dmem_busy),
        .ex_redirect (ex_redirect),
        .wb_halt     (wb_halt),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_write (exmem_write),
        .memwb_write (memwb_write),
        .imem_cancel (imem_cancel),
`ifdef PIPE_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .halted      (halted)
    );

    function automatic logic [7:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush,
                exmem_write, memwb_write, imem_cancel, halted};
    endfunction

    // Stimulus word: {rst, lu, imem, dmem, redirect, wb_halt}
    task automatic drive(input logic [5:0] s, input logic [7:0] e);
        {rst, lu_stall, imem_busy, dmem_busy, ex_redirect, wb_halt} = s;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(6'b100000, FRZ);
        @(posedge clk); #1;
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        logic [7:0] got, e;
        drive(6'b111110, FRZ);
        @(negedge clk);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=%b", got, e);
        end
        @(posedge clk); #1;
`ifdef PIPE_PERF_EN
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        logic [5:0] st [3] = '{6'b010000, 6'b000000, 6'b011000};
        logic [7:0] ex [3] = '{LU, ADV, LU};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e);
            end
`ifdef PIPE_PERF_EN
            if (i == 1) begin
                checks++;
                if (stall_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dmem_wait();
        logic [5:0] st [5] = '{6'b000110, 6'b000110, 6'b000110,
                               6'b000010, 6'b000000};
        logic [7:0] ex [5] = '{FRZ, FRZ, FRZ, RED, ADV};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dmem_wait[%0d] got=%b exp=%b", i, got, e);
            end
`ifdef PIPE_PERF_EN
            if (i == 4) begin
                checks++;
                if (flush_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL dw_flush_cnt got=%0d exp=1", flush_cnt);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_branch();
        logic [5:0] st [6] = '{6'b001000, 6'b001010, 6'b000000,
                               6'b001000, 6'b000010, 6'b000000};
        logic [7:0] ex [6] = '{IMB, REDC, ADV, IMB, REDC, ADV};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fetch_branch[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_lu();
        logic [5:0] st [3] = '{6'b010010, 6'b010000, 6'b000000};
        logic [7:0] ex [3] = '{RED, LU, ADV};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL redirect_lu[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [5:0] st [8] = '{6'b000101, 6'b000000, 6'b000001, 6'b010000,
                               6'b000010, 6'b001101, 6'b100000, 6'b000000};
        logic [7:0] ex [8] = '{FRZ, ADV, FRZ, HLT, HLT, HLT, HLT, ADV};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halt[%0d] got=%b exp=%b", i, got, e);
            end
`ifdef PIPE_PERF_EN
            if (i == 7) begin
                checks++;
                if (stall_cnt !== '0 || flush_cnt !== '0) begin
                    errors++;
                    $display("FAIL halt_cnt got=%0d/%0d exp=0/0",
                             stall_cnt, flush_cnt);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] st [7] = '{6'b000010, 6'b000010, 6'b001010, 6'b001000,
                               6'b001000, 6'b000010, 6'b000000};
        logic [7:0] ex [7] = '{RED, RED, REDC, IMB, IMB, REDC, ADV};
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] got, e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(6'b010000, LU);
            @(negedge clk);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sat_outs[%0d] got=%b exp=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
        drive(6'b000000, ADV);
        @(negedge clk);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL sat_after got=%b exp=%b", got, e);
        end
`ifdef PIPE_PERF_EN
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt got=%0d exp=15", stall_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        {rst, lu_stall, imem_busy, dmem_busy, ex_redirect, wb_halt} = 6'b100000;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_fetch_branch();
        test_redirect_lu();
        test_halt();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
